// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
//   uart_rx_state_e : receiver FSM state encoding
//   MIN_SCALER      : smallest supported cycles-per-bit value
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HI
  } uart_rx_state_e;

  localparam logic [15:0] MIN_SCALER = 16'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchroniser for the asynchronous serial line.
//   i_clk, i_rst : clock, async active-high reset (flops reset to 1 = line idle)
//   i_d          : asynchronous input
//   o_q          : synchronised output, SyncStages cycles late
module uart_rx_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SyncStages-1:0] stages;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stages <= '1;
    else       stages <= {stages[SyncStages-2:0], i_d};
  end

  assign o_q = stages[SyncStages-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1-style frames -> parallel word
// with a valid/ready output handshake.
//   i_clk, i_rst   : clock, async active-high reset
//   i_scaler       : clock cycles per bit (>= 4, stable while o_busy)
//   i_rx           : serial line, idle high
//   i_parity_odd   : parity sense (1 = odd) when parity is built in
//   o_data/o_valid : received word and its valid flag; i_ready consumes
//   o_busy         : receiver not idle
//   o_frame_err    : 1-cycle pulse, stop bit sampled low
//   o_parity_err   : 1-cycle pulse, parity mismatch (always 0 without parity)
//   o_overrun      : 1-cycle pulse, completed word dropped (o_valid still held)
// Build option: define UART_RX_PARITY_EN to receive a parity bit after the data.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DataBits   = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [15:0]         i_scaler,
  input  logic                i_rx,
  input  logic                i_parity_odd,
  output logic [DataBits-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_frame_err,
  output logic                o_parity_err,
  output logic                o_overrun
);

  localparam int unsigned IDX_W = $clog2(DataBits + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DataBits - 1);

  uart_rx_state_e      state, state_n;
  logic [15:0]         cnt, cnt_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [DataBits-1:0] shreg, shreg_n;
  logic                par_bit, par_n;
  logic                rx_s;
  logic                word_done, ferr, perr, parity_bad;
  logic [15:0]         half;
  logic                wrap;

  uart_rx_sync #(.SyncStages(SyncStages)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  assign half = {1'b0, i_scaler[15:1]};
  assign wrap = (cnt == i_scaler - 16'd1);

`ifdef UART_RX_PARITY_EN
  assign parity_bad = (par_bit != (^shreg ^ i_parity_odd));
`else
  assign parity_bad = i_parity_odd & 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    par_n     = par_bit;
    word_done = 1'b0;
    ferr      = 1'b0;
    perr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n = ST_START;
          cnt_n   = '0;
        end
      end
      ST_START: begin
        // Re-check the line half a bit after the falling edge to reject glitches.
        if (cnt == half - 16'd1) begin
          if (!rx_s) begin
            state_n = ST_DATA;
            cnt_n   = '0;
            idx_n   = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (wrap) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[DataBits-1:1]};
          idx_n   = idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_PARITY: begin
        if (wrap) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = ST_STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (wrap) begin
          cnt_n     = '0;
          perr      = parity_bad;
          word_done = rx_s & ~parity_bad;
          if (!rx_s) begin
            ferr    = 1'b1;
            state_n = ST_WAIT_HI;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ST_WAIT_HI: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      par_bit      <= par_n;
      o_frame_err  <= ferr;
      o_parity_err <= perr;
      o_overrun    <= word_done & o_valid & ~i_ready;
      // A completing word may replace the held one only if that one is consumed now.
      if (word_done && (!o_valid || i_ready)) begin
        o_data  <= shreg;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames driven onto i_rx, with outcomes
// predicted from the frame contents (data, stop level, parity) alone.
module tb_uart_rx;
  import uart_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_scaler;
  logic        i_rx;
  logic        i_parity_odd;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_frame_err;
  logic        o_parity_err;
  logic        o_overrun;

  uart_rx #(.DataBits(8), .SyncStages(2)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_scaler     (i_scaler),
    .i_rx         (i_rx),
    .i_parity_odd (i_parity_odd),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_overrun    (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Event monitor: sees pre-edge values at each rising edge.
  int   cyc = 0;
  int   ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0, rise_cnt = 0, rise_cyc = 0;
  bit   busy_seen = 0;
  logic valid_q = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge i_clk) begin
    cyc++;
    if (o_frame_err)  ferr_cnt++;
    if (o_parity_err) perr_cnt++;
    if (o_overrun)    ovr_cnt++;
    if (o_busy)       busy_seen = 1;
    if (o_valid && !valid_q) begin
      rise_cnt++;
      if (rise_cnt == 1) rise_cyc = cyc;
    end
    valid_q = o_valid;
    if (o_valid && i_ready) got_q.push_back(o_data);
  end

  task automatic clear_mon();
    ferr_cnt = 0; perr_cnt = 0; ovr_cnt = 0; rise_cnt = 0; rise_cyc = 0;
    busy_seen = 0;
    got_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic bit_period(input logic v);
    i_rx = v;
    repeat (int'(i_scaler)) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int gap);
    check("scaler_min", {31'd0, i_scaler >= MIN_SCALER}, 32'd1);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_period(par);
`else
    if (par) i_rx = 1'b1;
`endif
    bit_period(stop);
    i_rx = 1'b1;
    tick(gap);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      tick(1);
      n++;
    end
    check("idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q[$];
    int exp_ferr, exp_perr, start_cyc, lat, lat_exp;

    i_rst = 1'b1; i_rx = 1'b1; i_scaler = 16'd16; i_ready = 1'b1; i_parity_odd = 1'b0;
    tick(3);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data",  {24'd0, o_data}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_errs",  {29'd0, o_frame_err, o_parity_err, o_overrun}, 32'd0);
    i_rst = 1'b0;
    tick(5);

    // Basic frame and latency from the start edge
    clear_mon();
    start_cyc = cyc;
    send_frame(8'h5A, 1'b1, 1'b0, 20);
    lat     = rise_cyc - start_cyc;
    lat_exp = 2 + (19 * 16) / 2 + 1;
    check("lat_5a_window", {31'd0, (lat >= lat_exp - 3) && (lat <= lat_exp + 3)}, 32'd1);
    check("cnt_5a", rise_cnt, 1);
    check("len_5a", got_q.size(), 1);
    if (got_q.size() > 0) check("data_5a", {24'd0, got_q[0]}, 32'h5A);

    // Glitch shorter than half a bit
    clear_mon();
    i_rx = 1'b0; tick(5); i_rx = 1'b1; tick(30);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_now",  {31'd0, o_busy}, 32'd0);
    check("glitch_valid",     rise_cnt, 0);
    check("glitch_errs",      ferr_cnt + perr_cnt + ovr_cnt, 0);

    // Framing error, stuck-low line, then recovery
    clear_mon();
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    i_rx = 1'b0; tick(40);
    check("ferr_wait_hi_busy", {31'd0, o_busy}, 32'd1);
    check("ferr_cnt",          ferr_cnt, 1);
    check("ferr_no_valid",     rise_cnt, 0);
    i_rx = 1'b1;
    wait_idle(10);
    tick(5);
    send_frame(8'h01, 1'b1, 1'b1, 10);
    check("recover_len", got_q.size(), 1);
    if (got_q.size() > 0) check("recover_data", {24'd0, got_q[0]}, 32'h01);
    check("recover_ferr", ferr_cnt, 1);

    // Overrun: consumer stalled across two frames
    clear_mon();
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 2);
    send_frame(8'h22, 1'b1, 1'b0, 2);
    check("ovr_data",  {24'd0, o_data}, 32'h11);
    check("ovr_valid", {31'd0, o_valid}, 32'd1);
    check("ovr_cnt",   ovr_cnt, 1);
    i_ready = 1'b1;
    tick(2);
    check("ovr_valid_drop", {31'd0, o_valid}, 32'd0);
    check("ovr_len", got_q.size(), 1);
    if (got_q.size() > 0) check("ovr_consumed", {24'd0, got_q[0]}, 32'h11);

    // Reset in the middle of the data bits
    clear_mon();
    bit_period(1'b0); bit_period(1'b1); bit_period(1'b1); bit_period(1'b0);
    i_rst = 1'b1;
    #1;
    check("midrst_data",  {24'd0, o_data}, 32'd0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_busy",  {31'd0, o_busy}, 32'd0);
    check("midrst_errs",  {29'd0, o_frame_err, o_parity_err, o_overrun}, 32'd0);
    i_rx = 1'b1;
    tick(2);
    i_rst = 1'b0;
    tick(5);
    clear_mon();
    send_frame(8'h33, 1'b1, 1'b0, 10);
    check("resend_len", got_q.size(), 1);
    if (got_q.size() > 0) check("resend_data", {24'd0, got_q[0]}, 32'h33);
    check("resend_errs", ferr_cnt + perr_cnt + ovr_cnt, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity on 0x07 (three ones) needs parity bit 1
    clear_mon();
    i_parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 10);
    check("par_ok_len", got_q.size(), 1);
    if (got_q.size() > 0) check("par_ok_data", {24'd0, got_q[0]}, 32'h07);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 10);
    check("par_bad_perr",  perr_cnt, 1);
    check("par_bad_valid", rise_cnt, 0);
`endif

    // Randomized frames: scaler, data, stop level and parity all vary
    clear_mon();
    exp_q.delete();
    exp_ferr = 0;
    exp_perr = 0;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      logic       stop, par_good, par;
      wait_idle(200);
      i_scaler = (k == 0) ? 16'd4 : (k == 1) ? 16'd5 : 16'($urandom_range(4, 24));
      d        = 8'($urandom);
      stop     = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      i_parity_odd = 1'($urandom);
      par_good     = ($urandom_range(0, 3) != 0);
`else
      par_good     = 1'b1;
`endif
      // Correct parity bit makes total ones even (or odd when i_parity_odd).
      par = (^d) ^ i_parity_odd ^ ~par_good;
      if (stop && par_good) exp_q.push_back(d);
      if (!stop) exp_ferr++;
      if (!par_good) exp_perr++;
      send_frame(d, stop, par, $urandom_range(4, 12));
    end
    wait_idle(200);
    tick(4);
    check("rand_len",  got_q.size(), exp_q.size());
    check("rand_ferr", ferr_cnt, exp_ferr);
    check("rand_perr", perr_cnt, exp_perr);
    check("rand_ovr",  ovr_cnt, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_data_%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
